// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one read per cycle into a
// one-cycle-latency memory, and buffers one returning word so decode can stall.
module fetch_stage #(
  parameter int unsigned       WIDTH            = 36,
  parameter int unsigned       INSTRUCTIONWIDTH = 24,
  parameter logic [WIDTH-1:0]  RESET_PC         = '0,
  parameter logic [4:0]        HALT_OPCODE      = 5'h1F
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        stall,
  input  logic                        flush,
  input  logic [WIDTH-1:0]            target,
  output logic [WIDTH-1:0]            imem_addr,
  input  logic [INSTRUCTIONWIDTH-1:0] imem_rdata,
  output logic [INSTRUCTIONWIDTH-1:0] instr,
  output logic [WIDTH-1:0]            instr_pc,
  output logic                        instr_valid,
  output logic                        halted
);

  localparam int unsigned OPW = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_e;

  state_e                      state_q, state_d;
  logic [WIDTH-1:0]            pc_q, pc_d;
  logic                        f_valid_q, f_valid_d;
  logic [WIDTH-1:0]            f_pc_q, f_pc_d;
  logic                        sk_valid_q, sk_valid_d;
  logic [INSTRUCTIONWIDTH-1:0] sk_instr_q, sk_instr_d;
  logic [WIDTH-1:0]            sk_pc_q, sk_pc_d;
  logic                        instr_valid_q, instr_valid_d;
  logic [INSTRUCTIONWIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0]            instr_pc_q, instr_pc_d;
  logic                        halted_q, halted_d;

  logic                        issue;
  logic                        ld_valid;
  logic [INSTRUCTIONWIDTH-1:0] ld_instr;
  logic [WIDTH-1:0]            ld_pc;
  logic                        ld_is_halt;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      f_valid_q     <= 1'b0;
      f_pc_q        <= '0;
      sk_valid_q    <= 1'b0;
      sk_instr_q    <= '0;
      sk_pc_q       <= '0;
      instr_valid_q <= 1'b0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f_valid_q     <= f_valid_d;
      f_pc_q        <= f_pc_d;
      sk_valid_q    <= sk_valid_d;
      sk_instr_q    <= sk_instr_d;
      sk_pc_q       <= sk_pc_d;
      instr_valid_q <= instr_valid_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      halted_q      <= halted_d;
    end
  end

  // Candidate word for the output registers: skid content takes precedence
  always_comb begin
    ld_valid   = sk_valid_q | f_valid_q;
    ld_instr   = sk_valid_q ? sk_instr_q : imem_rdata;
    ld_pc      = sk_valid_q ? sk_pc_q : f_pc_q;
    ld_is_halt = (ld_instr[INSTRUCTIONWIDTH-1 -: OPW] == HALT_OPCODE);
    issue      = (state_q == S_FETCH) && !stall && !sk_valid_q && !flush;
  end

  // Next-state and datapath update
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f_valid_d     = 1'b0;
    f_pc_d        = f_pc_q;
    sk_valid_d    = sk_valid_q;
    sk_instr_d    = sk_instr_q;
    sk_pc_d       = sk_pc_q;
    instr_valid_d = instr_valid_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;

    if (flush && (state_q != S_IDLE)) begin
      state_d       = S_FETCH;
      pc_d          = target;
      sk_valid_d    = 1'b0;
      instr_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) state_d = S_FETCH;
        end
        S_FETCH: begin
          if (issue) begin
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            pc_d      = pc_q + WIDTH'(1);
          end
          if (!stall) begin
            sk_valid_d    = 1'b0;
            instr_valid_d = ld_valid;
            if (ld_valid) begin
              instr_d    = ld_instr;
              instr_pc_d = ld_pc;
              if (ld_is_halt) state_d = S_HALTED;
            end
          end else if (f_valid_q) begin
            sk_valid_d = 1'b1;
            sk_instr_d = imem_rdata;
            sk_pc_d    = f_pc_q;
          end
        end
        S_HALTED: begin
          // Anything still in flight after the halt word is dropped
          sk_valid_d = 1'b0;
          if (!stall) instr_valid_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end

    halted_d = (state_d == S_HALTED);
  end

  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-cycle-latency instruction memory model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        start;
  logic        stall;
  logic        flush;
  logic [35:0] target;
  logic [35:0] imem_addr;
  logic [23:0] imem_rdata;
  logic [23:0] instr;
  logic [35:0] instr_pc;
  logic        instr_valid;
  logic        halted;

  logic        halt_en;
  int          n_pass;
  int          n_total;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stall      (stall),
    .flush      (flush),
    .target     (target),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: opcode 0x02 with the low address bits, halt word at 5 when enabled
  function automatic logic [23:0] mem_word(input logic [35:0] a, input logic h);
    if (h && (a == 36'd5)) return {5'h1F, 19'd5};
    return {5'h02, a[18:0]};
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr, halt_en);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (imem_addr !== 36'd0) $display("FAIL reset_addr got %0h exp 0", imem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL reset_valid got %0b exp 0", instr_valid); else n_pass++;
    n_total++; if (instr !== 24'd0) $display("FAIL reset_instr got %0h exp 0", instr); else n_pass++;
    n_total++; if (instr_pc !== 36'd0) $display("FAIL reset_pc got %0h exp 0", instr_pc); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %0b exp 0", halted); else n_pass++;
    tick();
    rst = 1'b0;
    tick();
    n_total++; if (imem_addr !== 36'd0) $display("FAIL idle_addr got %0h exp 0", imem_addr); else n_pass++;
  endtask

  task automatic test_stream();
    start = 1'b1;
    tick();
    start = 1'b0;
    n_total++; if (imem_addr !== 36'd0) $display("FAIL start_e0_addr got %0h exp 0", imem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL start_e0_valid got %0b exp 0", instr_valid); else n_pass++;
    tick();
    n_total++; if (imem_addr !== 36'd1) $display("FAIL start_e1_addr got %0h exp 1", imem_addr); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL start_e1_valid got %0b exp 0", instr_valid); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (instr_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %0b exp 1", i, instr_valid); else n_pass++;
      n_total++; if (instr_pc !== 36'(i)) $display("FAIL stream_pc[%0d] got %0h exp %0h", i, instr_pc, i); else n_pass++;
      n_total++; if (instr !== mem_word(36'(i), 1'b0)) $display("FAIL stream_instr[%0d] got %0h exp %0h", i, instr, mem_word(36'(i), 1'b0)); else n_pass++;
      n_total++; if (imem_addr !== 36'(i + 2)) $display("FAIL stream_addr[%0d] got %0h exp %0h", i, imem_addr, i + 2); else n_pass++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (instr_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %0b exp 1", i, instr_valid); else n_pass++;
      n_total++; if (instr_pc !== 36'd2) $display("FAIL stall_pc[%0d] got %0h exp 2", i, instr_pc); else n_pass++;
      n_total++; if (instr !== mem_word(36'd2, 1'b0)) $display("FAIL stall_instr[%0d] got %0h exp %0h", i, instr, mem_word(36'd2, 1'b0)); else n_pass++;
      n_total++; if (imem_addr !== 36'd4) $display("FAIL stall_addr[%0d] got %0h exp 4", i, imem_addr); else n_pass++;
    end
    stall = 1'b0;
    tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL release_valid got %0b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 36'd3) $display("FAIL release_pc got %0h exp 3", instr_pc); else n_pass++;
    n_total++; if (instr !== mem_word(36'd3, 1'b0)) $display("FAIL release_instr got %0h exp %0h", instr, mem_word(36'd3, 1'b0)); else n_pass++;
    n_total++; if (imem_addr !== 36'd4) $display("FAIL release_addr got %0h exp 4", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL bubble_valid got %0b exp 0", instr_valid); else n_pass++;
    n_total++; if (imem_addr !== 36'd5) $display("FAIL bubble_addr got %0h exp 5", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL resume_valid got %0b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 36'd4) $display("FAIL resume_pc got %0h exp 4", instr_pc); else n_pass++;
    n_total++; if (imem_addr !== 36'd6) $display("FAIL resume_addr got %0h exp 6", imem_addr); else n_pass++;
  endtask

  task automatic test_flush_stall();
    stall = 1'b1;
    tick();
    n_total++; if (instr_pc !== 36'd4) $display("FAIL fs_hold_pc got %0h exp 4", instr_pc); else n_pass++;
    flush  = 1'b1;
    target = 36'd17;
    tick();
    flush = 1'b0;
    stall = 1'b0;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL fs_e0_valid got %0b exp 0", instr_valid); else n_pass++;
    n_total++; if (imem_addr !== 36'd17) $display("FAIL fs_e0_addr got %0h exp 17", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b0) $display("FAIL fs_e1_valid got %0b exp 0", instr_valid); else n_pass++;
    n_total++; if (imem_addr !== 36'd18) $display("FAIL fs_e1_addr got %0h exp 18", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL fs_e2_valid got %0b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 36'd17) $display("FAIL fs_e2_pc got %0h exp 17", instr_pc); else n_pass++;
    n_total++; if (instr !== mem_word(36'd17, 1'b0)) $display("FAIL fs_e2_instr got %0h exp %0h", instr, mem_word(36'd17, 1'b0)); else n_pass++;
    tick();
    n_total++; if (instr_pc !== 36'd18) $display("FAIL fs_e3_pc got %0h exp 18", instr_pc); else n_pass++;
  endtask

  task automatic test_halt();
    halt_en = 1'b1;
    flush   = 1'b1;
    target  = 36'd3;
    tick();
    flush = 1'b0;
    n_total++; if (imem_addr !== 36'd3) $display("FAIL halt_flush_addr got %0h exp 3", imem_addr); else n_pass++;
    repeat (2) tick();
    n_total++; if (instr_pc !== 36'd3) $display("FAIL halt_pc3 got %0h exp 3", instr_pc); else n_pass++;
    tick();
    n_total++; if (instr_pc !== 36'd4) $display("FAIL halt_pc4 got %0h exp 4", instr_pc); else n_pass++;
    n_total++; if (halted !== 1'b0) $display("FAIL halt_early got %0b exp 0", halted); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL halt_word_valid got %0b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 36'd5) $display("FAIL halt_word_pc got %0h exp 5", instr_pc); else n_pass++;
    n_total++; if (instr !== 24'hF80005) $display("FAIL halt_word_instr got %0h exp f80005", instr); else n_pass++;
    n_total++; if (halted !== 1'b1) $display("FAIL halt_state got %0b exp 1", halted); else n_pass++;
    n_total++; if (imem_addr !== 36'd7) $display("FAIL halt_addr got %0h exp 7", imem_addr); else n_pass++;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++; if (instr_valid !== 1'b0) $display("FAIL halted_valid[%0d] got %0b exp 0", i, instr_valid); else n_pass++;
      n_total++; if (halted !== 1'b1) $display("FAIL halted_hold[%0d] got %0b exp 1", i, halted); else n_pass++;
      n_total++; if (imem_addr !== 36'd7) $display("FAIL halted_addr[%0d] got %0h exp 7", i, imem_addr); else n_pass++;
    end
    halt_en = 1'b0;
    flush   = 1'b1;
    target  = 36'd0;
    tick();
    flush = 1'b0;
    n_total++; if (halted !== 1'b0) $display("FAIL unhalt_state got %0b exp 0", halted); else n_pass++;
    n_total++; if (imem_addr !== 36'd0) $display("FAIL unhalt_addr got %0h exp 0", imem_addr); else n_pass++;
    repeat (2) tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL restart_valid got %0b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 36'd0) $display("FAIL restart_pc got %0h exp 0", instr_pc); else n_pass++;
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL arst_valid got %0b exp 0", instr_valid); else n_pass++;
    n_total++; if (instr !== 24'd0) $display("FAIL arst_instr got %0h exp 0", instr); else n_pass++;
    n_total++; if (instr_pc !== 36'd0) $display("FAIL arst_pc got %0h exp 0", instr_pc); else n_pass++;
    n_total++; if (imem_addr !== 36'd0) $display("FAIL arst_addr got %0h exp 0", imem_addr); else n_pass++;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++; if (imem_addr !== 36'd0) $display("FAIL idle_noissue_addr[%0d] got %0h exp 0", i, imem_addr); else n_pass++;
      n_total++; if (instr_valid !== 1'b0) $display("FAIL idle_noissue_valid[%0d] got %0b exp 0", i, instr_valid); else n_pass++;
    end
  endtask

  task automatic test_wrap();
    start = 1'b1;
    tick();
    start  = 1'b0;
    flush  = 1'b1;
    target = '1;
    tick();
    flush = 1'b0;
    n_total++; if (imem_addr !== 36'hF_FFFF_FFFF) $display("FAIL wrap_addr_max got %0h exp fffffffff", imem_addr); else n_pass++;
    tick();
    n_total++; if (imem_addr !== 36'd0) $display("FAIL wrap_addr_zero got %0h exp 0", imem_addr); else n_pass++;
    tick();
    n_total++; if (instr_valid !== 1'b1) $display("FAIL wrap_valid got %0b exp 1", instr_valid); else n_pass++;
    n_total++; if (instr_pc !== 36'hF_FFFF_FFFF) $display("FAIL wrap_pc_max got %0h exp fffffffff", instr_pc); else n_pass++;
    n_total++; if (instr !== 24'h17FFFF) $display("FAIL wrap_instr_max got %0h exp 17ffff", instr); else n_pass++;
    tick();
    n_total++; if (instr_pc !== 36'd0) $display("FAIL wrap_pc_zero got %0h exp 0", instr_pc); else n_pass++;
    n_total++; if (instr !== 24'h100000) $display("FAIL wrap_instr_zero got %0h exp 100000", instr); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    start   = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    target  = '0;
    halt_en = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_halt();
    test_async_reset();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
